uart_rx: RTL

- 8x-oversampled UART receiver, immediately downstream of the baud generator; consumes its tick_8x strobe.
- Synchronises the serial line, detects and qualifies start bits, and majority-votes each bit at mid-period.
- Delivers LSB-first data words with optional parity check and a stop-bit check.
- Emits a one-cycle valid strobe per frame together with error flags.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int OVERSAMPLE = 8;
    localparam int PH_W       = $clog2(OVERSAMPLE);

    localparam logic [PH_W-1:0] SAMPLE_PH0 = PH_W'(3);
    localparam logic [PH_W-1:0] SAMPLE_PH1 = PH_W'(4);
    localparam logic [PH_W-1:0] SAMPLE_PH2 = PH_W'(5);
    localparam logic [PH_W-1:0] LAST_PH    = PH_W'(7);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: clocked state uses non-blocking assignments so both flops sample the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8x-oversampled UART receiver: start qualification, 2-of-3 mid-bit voting,
// LSB-first data, optional parity and stop-bit checking.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_8x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic       HAS_PARITY = (PARITY_EN != 0);
    localparam logic       ODD        = (PARITY_ODD != 0);
    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

    state_t                state;
    logic [PH_W-1:0]       ph;
    logic [2:0]            bit_idx;
    logic                  s3, s4;
    logic                  par_bit;
    logic [DATA_BITS-1:0]  shreg;
    logic                  rx_s;
    logic                  vote;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // The third vote is the live ph=5 sample, so the decision lands on that tick.
    assign vote = maj3(s3, s4, rx_s);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ph         <= '0;
            bit_idx    <= '0;
            s3         <= 1'b1;
            s4         <= 1'b1;
            par_bit    <= 1'b0;
            shreg      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (tick_8x) begin
                if (state != IDLE) ph <= ph + 1'b1;
                if (ph == SAMPLE_PH0) s3 <= rx_s;
                if (ph == SAMPLE_PH1) s4 <= rx_s;
                case (state)
                    IDLE: begin
                        // The detecting tick is phase 0, so the next tick is phase 1.
                        if (!rx_s) begin
                            state <= START;
                            ph    <= PH_W'(1);
                        end
                    end
                    START: begin
                        if (ph == SAMPLE_PH2 && vote) begin
                            state <= IDLE;
                        end else if (ph == LAST_PH) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        if (ph == SAMPLE_PH2) shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (ph == LAST_PH) begin
                            if (bit_idx == LAST_BIT) state <= HAS_PARITY ? PARITY : STOP;
                            else                     bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (ph == SAMPLE_PH2) par_bit <= vote;
                        if (ph == LAST_PH)    state   <= STOP;
                    end
                    STOP: begin
                        // Leave at mid-stop so a short stop bit still lets the next start resync.
                        if (ph == SAMPLE_PH2) begin
                            rx_data    <= shreg;
                            rx_valid   <= 1'b1;
                            parity_err <= HAS_PARITY && (par_bit != ((^shreg) ^ ODD));
                            frame_err  <= ~vote;
                            state      <= vote ? IDLE : WAIT_HIGH;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_s) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
